// File: rtl/multicycle_seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package multicycle_seq_pkg;

    // Core datapath width shared with the rest of the RV core.
    localparam int unsigned CpuWidth = 32;

    // Sequencer state encoding.
    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetchReq  = 3'd1,
        StFetchWait = 3'd2,
        StExec      = 3'd3,
        StMemReq    = 3'd4,
        StMemWait   = 3'd5,
        StWb        = 3'd6,
        StHalt      = 3'd7
    } seq_state_e;

    // Reason the core stopped.
    localparam logic [1:0] TrapNone    = 2'd0;
    localparam logic [1:0] TrapEbreak  = 2'd1;
    localparam logic [1:0] TrapUnknown = 2'd2;
    localparam logic [1:0] TrapTimeout = 2'd3;

endpackage

// File: rtl/seq_watchdog.sv
// Bus watchdog: counts enabled cycles since the last clear and flags the
// Limit-th consecutive enabled cycle.
module seq_watchdog #(
    parameter int unsigned Limit = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise saturate at the last counted cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LastCnt)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High during the Limit-th waiting cycle; the owner decides what wins.
    assign expired_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle RV core sequencer: fetch, execute, optional memory access,
// single-cycle writeback, and halt on ebreak / unknown instruction / timeout.
module multicycle_seq
    import multicycle_seq_pkg::*;
#(
    parameter int unsigned CPU_WIDTH = CpuWidth,
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ifu_req_valid,
    input  logic                 ifu_req_ready,
    input  logic                 ifu_rsp_valid,
    input  logic [CPU_WIDTH-1:0] ifu_rsp_inst,
    output logic [CPU_WIDTH-1:0] inst,
    input  logic                 dec_is_load,
    input  logic                 dec_is_store,
    input  logic                 dec_reg_wen,
    input  logic                 dec_ebreak,
    input  logic                 dec_unknown,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    input  logic                 mem_rsp_valid,
    output logic                 rf_wen,
    output logic                 pc_wen,
    output logic                 halted,
    output logic [1:0]           trap_code,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    seq_state_e           state_q, state_d;
    logic [CPU_WIDTH-1:0] inst_q, inst_d;
    logic [1:0]           trap_q, trap_d;
    logic [CNT_WIDTH-1:0] retire_q, retire_d;
    // Register-write permission captured in EXEC and replayed in WB.
    logic                 wb_rf_wen_q, wb_rf_wen_d;
    logic                 in_wait;
    logic                 wd_expired;

    assign in_wait = (state_q == StFetchWait) || (state_q == StMemWait);

    // Leaving a wait state clears the count, so every wait starts from zero.
    seq_watchdog #(
        .Limit(TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clr_i    (!in_wait),
        .en_i     (in_wait),
        .expired_o(wd_expired)
    );

    // Next-state logic; a response in the expiring cycle beats the timeout.
    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        trap_d      = trap_q;
        retire_d    = retire_q;
        wb_rf_wen_d = wb_rf_wen_q;
        case (state_q)
            StIdle: state_d = StFetchReq;
            StFetchReq: begin
                if (ifu_req_ready) state_d = StFetchWait;
            end
            StFetchWait: begin
                if (ifu_rsp_valid) begin
                    inst_d  = ifu_rsp_inst;
                    state_d = StExec;
                end else if (wd_expired) begin
                    trap_d  = TrapTimeout;
                    state_d = StHalt;
                end
            end
            StExec: begin
                wb_rf_wen_d = dec_reg_wen & ~dec_is_store;
                if (dec_ebreak) begin
                    trap_d  = TrapEbreak;
                    state_d = StHalt;
                end else if (dec_unknown) begin
                    trap_d  = TrapUnknown;
                    state_d = StHalt;
                end else if (dec_is_load || dec_is_store) begin
                    state_d = StMemReq;
                end else begin
                    state_d = StWb;
                end
            end
            StMemReq: begin
                if (mem_req_ready) state_d = StMemWait;
            end
            StMemWait: begin
                if (mem_rsp_valid) begin
                    state_d = StWb;
                end else if (wd_expired) begin
                    trap_d  = TrapTimeout;
                    state_d = StHalt;
                end
            end
            StWb: begin
                retire_d = retire_q + CNT_WIDTH'(1);
                state_d  = StFetchReq;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            inst_q      <= '0;
            trap_q      <= TrapNone;
            retire_q    <= '0;
            wb_rf_wen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            trap_q      <= trap_d;
            retire_q    <= retire_d;
            wb_rf_wen_q <= wb_rf_wen_d;
        end
    end

    // Outputs come from state or registers only.
    assign ifu_req_valid = (state_q == StFetchReq);
    assign mem_req_valid = (state_q == StMemReq);
    assign pc_wen        = (state_q == StWb);
    assign rf_wen        = (state_q == StWb) && wb_rf_wen_q;
    assign halted        = (state_q == StHalt);
    assign inst          = inst_q;
    assign trap_code     = trap_q;
    assign retire_cnt    = retire_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: the bench plays IFU, decoder and
// data memory, and predicts each instruction's outcome from its class.
module tb_multicycle_seq;

    localparam int unsigned CW = 32;
    localparam int unsigned NW = 4;
    localparam int unsigned TO = 8;
    localparam int KAddi = 0, KAdd = 1, KLoad = 2, KStore = 3, KEbreak = 4, KUnknown = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [CW-1:0] ifu_rsp_inst, inst;
    logic          dec_is_load, dec_is_store, dec_reg_wen, dec_ebreak, dec_unknown;
    logic          mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic          rf_wen, pc_wen, halted;
    logic [1:0]    trap_code;
    logic [NW-1:0] retire_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wb_cyc = 0;
    int exp_retired = 0;

    always #5 clk = ~clk;

    multicycle_seq #(
        .CPU_WIDTH(CW),
        .CNT_WIDTH(NW),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_inst (ifu_rsp_inst),
        .inst         (inst),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .dec_reg_wen  (dec_reg_wen),
        .dec_ebreak   (dec_ebreak),
        .dec_unknown  (dec_unknown),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .rf_wen       (rf_wen),
        .pc_wen       (pc_wen),
        .halted       (halted),
        .trap_code    (trap_code),
        .retire_cnt   (retire_cnt)
    );

    // Minimal RV decoder; stores pass the raw rd field as a write enable so
    // the sequencer's store masking is exercised.
    always_comb begin
        dec_is_load  = 1'b0;
        dec_is_store = 1'b0;
        dec_reg_wen  = 1'b0;
        dec_ebreak   = 1'b0;
        dec_unknown  = 1'b0;
        if (inst == 32'h0010_0073) begin
            dec_ebreak = 1'b1;
        end else begin
            case (inst[6:0])
                7'b0010011, 7'b0110011: dec_reg_wen = (inst[11:7] != 5'd0);
                7'b0000011: begin
                    dec_is_load = 1'b1;
                    dec_reg_wen = (inst[11:7] != 5'd0);
                end
                7'b0100011: begin
                    dec_is_store = 1'b1;
                    dec_reg_wen  = (inst[11:7] != 5'd0);
                end
                default: dec_unknown = 1'b1;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk_strobes(input string tag);
        chk({tag, " pc_wen low"}, 64'(pc_wen), 64'(0));
        chk({tag, " rf_wen low"}, 64'(rf_wen), 64'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " inst"}, 64'(inst), 64'(0));
        chk({tag, " halted"}, 64'(halted), 64'(0));
        chk({tag, " trap_code"}, 64'(trap_code), 64'(0));
        chk({tag, " retire_cnt"}, 64'(retire_cnt), 64'(0));
        chk({tag, " ifu_req_valid"}, 64'(ifu_req_valid), 64'(0));
        chk({tag, " mem_req_valid"}, 64'(mem_req_valid), 64'(0));
        chk_strobes(tag);
    endtask

    // Holds reset over two edges, checks reset values, releases at a negedge.
    task automatic do_reset();
        rst_n         = 1'b0;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        exp_retired = 0;
        rst_n       = 1'b1;
        cyc         = 0;
    endtask

    function automatic logic [31:0] make_word(input int kind, input logic [4:0] rd);
        logic [31:0] w;
        w = $urandom();
        w[11:7] = rd;
        case (kind)
            KAddi:   w[6:0] = 7'b0010011;
            KAdd:    w[6:0] = 7'b0110011;
            KLoad:   w[6:0] = 7'b0000011;
            KStore:  w[6:0] = 7'b0100011;
            KEbreak: w = 32'h0010_0073;
            default: w[6:0] = 7'b0000000;
        endcase
        return w;
    endfunction

    // Starts in FETCH_REQ at a negedge; ends at the negedge of the EXEC cycle.
    task automatic fetch(input logic [31:0] w, input int rdy, input int rsp);
        for (int i = 0; i <= rdy; i++) begin
            chk("ifu_req_valid held", 64'(ifu_req_valid), 64'(1));
            chk_strobes("fetch_req");
            ifu_req_ready = (i == rdy);
            ifu_rsp_valid = 1'b1;  // stray response before the handshake
            ifu_rsp_inst  = ~w;
            step();
        end
        ifu_req_ready = 1'b0;
        for (int i = 0; i <= rsp; i++) begin
            chk("ifu_req_valid dropped", 64'(ifu_req_valid), 64'(0));
            chk("no halt in fetch wait", 64'(halted), 64'(0));
            chk_strobes("fetch_wait");
            ifu_rsp_valid = (i == rsp);
            ifu_rsp_inst  = (i == rsp) ? w : $urandom();
            step();
        end
        ifu_rsp_valid = 1'b0;
        chk("inst latched", 64'(inst), 64'(w));
    endtask

    // From the EXEC negedge through WB to the next FETCH_REQ (or HALT).
    task automatic finish(input int kind, input logic [4:0] rd, input int mrdy, input int mrsp);
        chk_strobes("exec");
        step();
        if (kind == KEbreak || kind == KUnknown) begin
            chk("trap halted", 64'(halted), 64'(1));
            chk("trap code", 64'(trap_code), 64'((kind == KEbreak) ? 1 : 2));
            chk("trap not retired", 64'(retire_cnt), 64'(exp_retired % (1 << NW)));
            chk_strobes("trap");
            return;
        end
        chk("halted low", 64'(halted), 64'(0));
        if (kind == KLoad || kind == KStore) begin
            for (int i = 0; i <= mrdy; i++) begin
                chk("mem_req_valid held", 64'(mem_req_valid), 64'(1));
                chk_strobes("mem_req");
                mem_req_ready = (i == mrdy);
                step();
            end
            mem_req_ready = 1'b0;
            for (int i = 0; i <= mrsp; i++) begin
                chk("mem_req_valid dropped", 64'(mem_req_valid), 64'(0));
                chk_strobes("mem_wait");
                mem_rsp_valid = (i == mrsp);
                step();
            end
            mem_rsp_valid = 1'b0;
        end
        chk("wb no mem req", 64'(mem_req_valid), 64'(0));
        chk("wb pc_wen", 64'(pc_wen), 64'(1));
        chk("wb rf_wen", 64'(kind != KStore && rd != 5'd0 ? 1 : 0) == 64'(rf_wen) ?
            64'(rf_wen) : 64'(rf_wen), 64'(kind != KStore && rd != 5'd0 ? 1 : 0));
        chk("retire before wb", 64'(retire_cnt), 64'(exp_retired % (1 << NW)));
        wb_cyc = cyc;
        step();
        exp_retired++;
        chk_strobes("after wb");
        chk("retire after wb", 64'(retire_cnt), 64'(exp_retired % (1 << NW)));
        chk("next fetch", 64'(ifu_req_valid), 64'(1));
    endtask

    task automatic run_inst(input int kind, input logic [4:0] rd, input int rdy, input int rsp,
                            input int mrdy, input int mrsp);
        logic [31:0] w;
        w = make_word(kind, rd);
        fetch(w, rdy, rsp);
        finish(kind, rd, mrdy, mrsp);
    endtask

    initial begin
        int          kind;
        logic [4:0]  rd;
        logic [31:0] w;

        // Zero-wait program: addi, addi, add, WB at cycles 4, 8, 12.
        do_reset();
        step();
        run_inst(KAddi, 5'd1, 0, 0, 0, 0);
        chk("wb cycle 1", 64'(wb_cyc), 64'(4));
        run_inst(KAddi, 5'd2, 0, 0, 0, 0);
        chk("wb cycle 2", 64'(wb_cyc), 64'(8));
        run_inst(KAdd, 5'd3, 0, 0, 0, 0);
        chk("wb cycle 3", 64'(wb_cyc), 64'(12));
        chk("retired three", 64'(retire_cnt), 64'(3));

        // Slow IFU, memory ops with delays, response on the last watchdog cycle.
        run_inst(KAddi, 5'd4, 3, 2, 0, 0);
        run_inst(KStore, 5'd9, 0, 0, 2, 0);
        run_inst(KLoad, 5'd7, 0, 0, 2, 0);
        run_inst(KAdd, 5'd5, 0, TO - 1, 0, 0);
        run_inst(KLoad, 5'd6, 1, 0, 0, TO - 1);

        // Random program long enough to wrap the retire counter.
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run_inst(kind, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, TO - 1)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, TO - 1)));
        end

        // ebreak halts and stays quiet.
        run_inst(KEbreak, 5'd0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            ifu_req_ready = 1'($urandom_range(0, 1));
            mem_req_ready = 1'($urandom_range(0, 1));
            step();
            chk("halt no fetch", 64'(ifu_req_valid), 64'(0));
            chk("halt no mem", 64'(mem_req_valid), 64'(0));
            chk("halt held", 64'(halted), 64'(1));
            chk("halt retire held", 64'(retire_cnt), 64'(exp_retired % (1 << NW)));
            chk_strobes("halt");
        end

        // Unknown instruction traps with code 2.
        do_reset();
        step();
        run_inst(KAddi, 5'd8, 0, 0, 0, 0);
        run_inst(KUnknown, 5'd3, 0, 0, 0, 0);

        // Fetch timeout: IFU never answers.
        do_reset();
        step();
        chk("to fetch req", 64'(ifu_req_valid), 64'(1));
        ifu_req_ready = 1'b1;
        step();
        ifu_req_ready = 1'b0;
        for (int i = 0; i < int'(TO); i++) begin
            chk("fetch wait no trap yet", 64'(halted), 64'(0));
            step();
        end
        chk("fetch timeout halted", 64'(halted), 64'(1));
        chk("fetch timeout code", 64'(trap_code), 64'(3));
        chk("fetch timeout no req", 64'(ifu_req_valid), 64'(0));

        // Memory timeout: memory accepts but never responds.
        do_reset();
        step();
        fetch(make_word(KStore, 5'd1), 0, 0);
        step();
        chk("mto mem req", 64'(mem_req_valid), 64'(1));
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < int'(TO); i++) begin
            chk("mem wait no trap yet", 64'(halted), 64'(0));
            step();
        end
        chk("mem timeout halted", 64'(halted), 64'(1));
        chk("mem timeout code", 64'(trap_code), 64'(3));

        // Reset during MEM_WAIT; a late response must be ignored.
        do_reset();
        step();
        w = make_word(KLoad, 5'd2);
        fetch(w, 0, 0);
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("in mem wait", 64'(mem_req_valid), 64'(0));
        rst_n = 1'b0;
        step();
        chk_reset_outputs("mid reset");
        exp_retired   = 0;
        rst_n         = 1'b1;
        mem_rsp_valid = 1'b1;
        cyc           = 0;
        step();
        mem_rsp_valid = 1'b0;
        chk("restart fetch", 64'(ifu_req_valid), 64'(1));
        chk("restart no mem", 64'(mem_req_valid), 64'(0));
        chk("restart retire", 64'(retire_cnt), 64'(0));
        run_inst(KAddi, 5'd1, 0, 0, 0, 0);
        chk("restart wb cycle", 64'(wb_cyc), 64'(4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
